// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp codes for the highway / farm-road intersection controller.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        HG_FR   = 3'd0,
        HY_FR   = 3'd1,
        HR_FG   = 3'd2,
        HR_FY   = 3'd3,
        ALLRED1 = 3'd4,
        ALLRED2 = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Clock-enable divider: one-cycle tick every TICK_DIV clocks (constant high when TICK_DIV = 1).
module traffic_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light.sv
// Moore intersection controller: highway green by default, farm-road cycle on synced sensor request.
// Optional all-red clearance phases when TRAFFIC_ALL_RED_EN is defined.
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV            = 1,
    parameter int YELLOW_TICKS        = 3,
    parameter int FARM_GREEN_TICKS    = 10,
    parameter int HWY_MIN_GREEN_TICKS = 4
`ifdef TRAFFIC_ALL_RED_EN
    ,
    parameter int ALL_RED_TICKS       = 1
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm
);

`ifdef TRAFFIC_ALL_RED_EN
    localparam int MAX_TICKS = max_int(max_int(YELLOW_TICKS, FARM_GREEN_TICKS),
                                       max_int(HWY_MIN_GREEN_TICKS, ALL_RED_TICKS));
`else
    localparam int MAX_TICKS = max_int(max_int(YELLOW_TICKS, FARM_GREEN_TICKS),
                                       HWY_MIN_GREEN_TICKS);
`endif
    localparam int TW = $clog2(MAX_TICKS) + 1;

    localparam logic [TW-1:0] YELLOW_LAST  = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] FARM_LAST    = TW'(FARM_GREEN_TICKS - 1);
    localparam logic [TW-1:0] HWY_MIN_LAST = TW'(HWY_MIN_GREEN_TICKS - 1);
`ifdef TRAFFIC_ALL_RED_EN
    localparam logic [TW-1:0] ALL_RED_LAST = TW'(ALL_RED_TICKS - 1);
`endif

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          tick;
    logic          sync_meta;
    logic          sensor_sync;

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_meta   <= 1'b0;
            sensor_sync <= 1'b0;
        end else begin
            sync_meta   <= sensor;
            sensor_sync <= sync_meta;
        end
    end

    // Timer restarts with each phase so every comparison below is phase-relative.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= HG_FR;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (tick && (timer != '1)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HG_FR: begin
                if (tick && sensor_sync && (timer >= HWY_MIN_LAST)) state_next = HY_FR;
            end
            HY_FR: begin
`ifdef TRAFFIC_ALL_RED_EN
                if (tick && (timer == YELLOW_LAST)) state_next = ALLRED1;
`else
                if (tick && (timer == YELLOW_LAST)) state_next = HR_FG;
`endif
            end
            HR_FG: begin
                if (tick && (timer == FARM_LAST)) state_next = HR_FY;
            end
            HR_FY: begin
`ifdef TRAFFIC_ALL_RED_EN
                if (tick && (timer == YELLOW_LAST)) state_next = ALLRED2;
`else
                if (tick && (timer == YELLOW_LAST)) state_next = HG_FR;
`endif
            end
`ifdef TRAFFIC_ALL_RED_EN
            ALLRED1: begin
                if (tick && (timer == ALL_RED_LAST)) state_next = HR_FG;
            end
            ALLRED2: begin
                if (tick && (timer == ALL_RED_LAST)) state_next = HG_FR;
            end
`endif
            default: state_next = HG_FR;
        endcase
    end

    always_comb begin
        light_highway = LAMP_RED;
        light_farm    = LAMP_RED;
        case (state)
            HG_FR: light_highway = LAMP_GREEN;
            HY_FR: light_highway = LAMP_YELLOW;
            HR_FG: light_farm    = LAMP_GREEN;
            HR_FY: light_farm    = LAMP_YELLOW;
            default: begin
                light_highway = LAMP_RED;
                light_farm    = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench: expected lamp pairs are queued per cycle from the phase durations and checked every clock.
module tb_traffic_light;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor;
    logic [2:0] light_highway;
    logic [2:0] light_farm;

    logic [5:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;

    traffic_light dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor        (sensor),
        .light_highway (light_highway),
        .light_farm    (light_farm)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [2:0] hw, input logic [2:0] fm, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({hw, fm});
    endtask

    // Clearance phase only exists when the optional feature is built in.
    task automatic push_all_red();
`ifdef TRAFFIC_ALL_RED_EN
        push(R, R, 1);
`endif
    endtask

    task automatic drain(input string tag);
        logic [5:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests++;
            assert ({light_highway, light_farm} === e) else begin
                fails++;
                $error("FAIL %s: observed hwy=%b farm=%b, expected hwy=%b farm=%b",
                       tag, light_highway, light_farm, e[5:3], e[2:0]);
            end
            tests++;
            assert ((light_highway === R) || (light_farm === R)) else begin
                fails++;
                $error("FAIL %s_safety: observed hwy=%b farm=%b, expected one side red",
                       tag, light_highway, light_farm);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        sensor = 1'b0;

        // Reset held two clocks, then long idle highway green.
        push(G, R, 2);
        drain("reset");
        rst_n = 1'b0;
        push(G, R, 60);
        drain("idle");

        // Single request: yellow appears three clocks after the sensor rises.
        sensor = 1'b1;
        push(G, R, 2); push(Y, R, 3);
        drain("single_a");
        sensor = 1'b0;
        push_all_red(); push(R, G, 10); push(R, Y, 3); push_all_red(); push(G, R, 8);
        drain("single_b");

        // Continuous request; drop sensor two clocks into the last farm green.
        sensor = 1'b1;
        push(G, R, 2); push(Y, R, 3); push_all_red(); push(R, G, 10); push(R, Y, 3); push_all_red();
        for (int p = 0; p < 2; p++) begin
            push(G, R, 4); push(Y, R, 3); push_all_red(); push(R, G, 10); push(R, Y, 3); push_all_red();
        end
        push(G, R, 4); push(Y, R, 3); push_all_red(); push(R, G, 2);
        drain("continuous");
        sensor = 1'b0;
        push(R, G, 8); push(R, Y, 3); push_all_red(); push(G, R, 10);
        drain("sensor_drop");

        // Reset during farm green, sensor still requesting.
        sensor = 1'b1;
        push(G, R, 2); push(Y, R, 3); push_all_red(); push(R, G, 5);
        drain("pre_reset");
        rst_n = 1'b1;
        push(G, R, 1);
        drain("mid_reset");
        rst_n = 1'b0;
        push(G, R, 3); push(Y, R, 3); push_all_red(); push(R, G, 2);
        drain("post_reset");
        sensor = 1'b0;
        push(R, G, 8); push(R, Y, 3); push_all_red(); push(G, R, 10);
        drain("post_reset_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Moore FSM controlling a highway / farm-road intersection; highway is green by default.
- A farm-road vehicle sensor requests a cycle: highway goes yellow then red, farm road goes green for a fixed time, then yellow, then back to highway green.
- Leaf block in the intersection controller. Timing is counted in "ticks" from an internal clock-enable divider.

Parameters:
- TICK_DIV, 1, clk cycles per timing tick (1 = every cycle; for example 50_000_000 gives 1 s at 50 MHz).
- YELLOW_TICKS, 3, duration of either yellow phase.
- FARM_GREEN_TICKS, 10, duration of farm-road green.
- HWY_MIN_GREEN_TICKS, 4, minimum highway green before a sensor request is honoured.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous reset, active-high (asserted = 1, despite the suffix).
- sensor  input  1  farm-road vehicle present, asynchronous to clk.
- light_highway  output  3  highway lamp, one-hot {red,yellow,green}.
- light_farm  output  3  farm lamp, one-hot {red,yellow,green}.

Behaviour:
- Lamp encoding: GREEN=3'b001, YELLOW=3'b010, RED=3'b100. Exactly one bit set per output at all times.
- sensor passes through a 2-flop synchronizer. Response latency is 2 clk.
- Tick generator:
  - Counts 0..TICK_DIV-1 and pulses tick for one clk at terminal count.
  - With TICK_DIV=1, tick is constant 1.
- Phase timer:
  - Cleared on every state change.
  - Increments on tick, saturating at its maximum.
  - Width is $clog2 of the largest tick parameter, plus 1.
- States and outputs (outputs decoded from the state register, no combinational path from sensor):
  - HG_FR: highway 001, farm 100. Reset state.
  - HY_FR: highway 010, farm 100.
  - HR_FG: highway 100, farm 001.
  - HR_FY: highway 100, farm 010.
- Transitions (on a tick edge with timer == N-1, so each phase lasts N ticks):
  - HG_FR -> HY_FR when synced sensor = 1 and timer >= HWY_MIN_GREEN_TICKS-1. Otherwise stay; highway green is unbounded while sensor = 0.
  - HY_FR -> HR_FG after YELLOW_TICKS.
  - HR_FG -> HR_FY after FARM_GREEN_TICKS, regardless of sensor. A sensor drop does not shorten farm green.
  - HR_FY -> HG_FR after YELLOW_TICKS. The highway minimum-green timer restarts.
- Sensor held high continuously: cycles repeat, with HWY_MIN_GREEN_TICKS of highway green between farm cycles (no starvation).
- Sensor pulse shorter than 1 clk after sync may be missed. This is acceptable; no latching.
- Reset (any time, mid-phase included), on the next clk edge:
  - state = HG_FR, timer = 0, divider = 0, synchronizer flops = 0.
  - Outputs: light_highway = 001, light_farm = 100.
- Illegal state encodings recover to HG_FR on the next clk.
- Safety invariant: highway and farm are never simultaneously non-red.

Optional Feature:
- Macro TRAFFIC_ALL_RED_EN.
- When defined: adds parameter ALL_RED_TICKS (default 1) and two clearance states:
  - ALLRED1 between HY_FR and HR_FG.
  - ALLRED2 between HR_FY and HG_FR.
  - Both drive highway 100 and farm 100 and each lasts ALL_RED_TICKS.
- When undefined: yellow goes directly to the opposing green as listed above. No extra states or logic.

Decomposition:
- Package traffic_light_pkg:
  - State enum typedef (including the all-red states, which are unused when the macro is off).
  - Lamp localparams LAMP_RED, LAMP_YELLOW, LAMP_GREEN.
- One sub-module, traffic_tick_gen:
  - Parameter TICK_DIV; ports clk, rst_n, tick.
- Synchronizer and FSM stay inline.

Test Plan:
- All tests use TICK_DIV=1, YELLOW=3, FARM_GREEN=10, HWY_MIN=4, macro off unless stated.
- Reset: hold rst_n=1 for 2 clk with sensor=0 -> light_highway=001, light_farm=100. Release and keep sensor=0 for 60 clk -> outputs unchanged.
- Single request: assert sensor at clk k (after more than 4 clk of green):
  - highway=010 from k+3 for 3 clk.
  - Then highway=100 / farm=001 for 10 clk.
  - Then farm=010 for 3 clk.
  - Then back to 001/100.
- Continuous sensor=1: period is 4+3+10+3 = 20 clk. Highway green lasts exactly 4 clk between cycles. Invariant check never fails.
- Sensor drop: deassert sensor 2 clk into farm green -> farm green still lasts 10 clk.
- Mid-phase reset: assert rst_n during HR_FG -> next edge outputs 001/100. Sequence restarts with a fresh minimum green.
- Macro on, ALL_RED_TICKS=1 -> one clk of 100/100 after each yellow; period becomes 22 clk under continuous sensor.
